irq_ipl_ctrl: RTL and testbench

- CPU-side responder for the interrupt request/acknowledge protocol.
- Merges Paula's encoded interrupt level (1-6) with the level-7 NMI request raised by the freezer cart.
- Presents a debounced, stable active-low IPL to the 68k core.
- Detects interrupt-acknowledge (IACK) cycles, answers them with an autovector VPA handshake, and retires latched NMIs on level-7 acknowledge.

---
 rtl/irq_ipl_if.sv | 26 ++
 rtl/irq_ipl_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_irq_ipl_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ipl_if.sv
// Interrupt/bus signal bundle between Paula, the freezer cart, the 68k core and irq_ipl_ctrl.
// The master side drives the requests and the CPU bus; the slave side is the controller.
interface irq_ipl_if;
   logic        clk7_en;
   logic [2:0]  paula_ipl;
   logic        int7;
   logic [23:1] cpu_address;
   logic        _cpu_as;
   logic [2:0]  cpu_fc;
   logic        cpu_rd;
   logic [2:0]  _cpu_ipl;
   logic        _cpu_vpa;
   logic        iack;
   logic [2:0]  iack_level;
   logic        nmi_pending;

   modport master (
      output clk7_en, paula_ipl, int7, cpu_address, _cpu_as, cpu_fc, cpu_rd,
      input  _cpu_ipl, _cpu_vpa, iack, iack_level, nmi_pending
   );

   modport slave (
      input  clk7_en, paula_ipl, int7, cpu_address, _cpu_as, cpu_fc, cpu_rd,
      output _cpu_ipl, _cpu_vpa, iack, iack_level, nmi_pending
   );
endinterface

// File: rtl/irq_ipl_ctrl.sv
// 68k interrupt responder: merges Paula levels with the freezer NMI, debounces the IPL,
// and answers IACK cycles with an autovector VPA handshake.
module irq_ipl_ctrl #(
   parameter int unsigned STABLE_CNT = 2,
   parameter int unsigned VPA_DLY    = 3
) (
   input  logic     clk,
   input  logic     _reset,
   irq_ipl_if.slave bus
);
   localparam logic [2:0] STABLE_MAX = 3'(STABLE_CNT);
   localparam logic [3:0] VPA_LOAD   = 4'(VPA_DLY);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ASSERT = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] dly_q, dly_d;
   logic [2:0] lvl_q, lvl_d;
   logic       int7_q;
   logic       nmi_q, nmi_d;
   logic [2:0] req_s;
   logic [2:0] cand_q, cand_d;
   logic [2:0] cnt_q, cnt_d;
   logic [2:0] ipl_q, ipl_d;
   logic       vpa_q, vpa_d;
   logic       iack_q, iack_d;
   logic [2:0] iack_lvl_q, iack_lvl_d;
   logic       iack_hit_s;

   assign iack_hit_s = !bus._cpu_as && (bus.cpu_fc == 3'b111) && bus.cpu_rd &&
                       (&bus.cpu_address[23:4]) && (bus.cpu_address[3:1] != 3'd0);

   // NMI latch (a new rising edge beats a level-7 retire) and requested level.
   always_comb begin
      if (bus.int7 && !int7_q) begin
         nmi_d = 1'b1;
      end else if (iack_q && (iack_lvl_q == 3'd7)) begin
         nmi_d = 1'b0;
      end else begin
         nmi_d = nmi_q;
      end
      if (bus.int7 || nmi_q) begin
         req_s = 3'd7;
      end else if (bus.paula_ipl == 3'd7) begin
         req_s = 3'd6;
      end else begin
         req_s = bus.paula_ipl;
      end
   end

   // Stabilizer: a level must be sampled STABLE_CNT times in a row before it is presented.
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (bus.clk7_en) begin
         if (req_s == cand_q) begin
            if (cnt_q < STABLE_MAX) begin
               cnt_d = cnt_q + 3'd1;
            end else begin
               cnt_d = cnt_q;
            end
         end else begin
            cand_d = req_s;
            cnt_d  = 3'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end
      if (cnt_q == STABLE_MAX) begin
         ipl_d = ~cand_q;
      end else begin
         ipl_d = ipl_q;
      end
   end

   // Edge register, NMI latch and stabilizer state.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         int7_q <= 1'b0;
         nmi_q  <= 1'b0;
         cand_q <= 3'd0;
         cnt_q  <= 3'd0;
         ipl_q  <= 3'b111;
      end else begin
         int7_q <= bus.int7;
         nmi_q  <= nmi_d;
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         ipl_q  <= ipl_d;
      end
   end

   // IACK FSM state register.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state_q <= ST_IDLE;
         dly_q   <= 4'd0;
         lvl_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         lvl_q   <= lvl_d;
      end
   end

   // IACK FSM next state; an address strobe release in WAIT aborts silently.
   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      lvl_d   = lvl_q;
      case (state_q)
         ST_IDLE: begin
            if (iack_hit_s) begin
               state_d = ST_WAIT;
               dly_d   = VPA_LOAD;
               lvl_d   = bus.cpu_address[3:1];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (bus._cpu_as) begin
               state_d = ST_IDLE;
            end else if (bus.clk7_en) begin
               if (dly_q <= 4'd1) begin
                  state_d = ST_ASSERT;
                  dly_d   = 4'd0;
               end else begin
                  dly_d = dly_q - 4'd1;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_ASSERT: begin
            if (bus._cpu_as) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ASSERT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // IACK FSM outputs, derived from the transition being taken.
   always_comb begin
      vpa_d  = (state_d == ST_ASSERT) ? 1'b0 : 1'b1;
      iack_d = (state_q == ST_WAIT) && (state_d == ST_ASSERT);
      if (iack_d) begin
         iack_lvl_d = lvl_q;
      end else begin
         iack_lvl_d = iack_lvl_q;
      end
   end

   // Registered bus outputs.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         vpa_q      <= 1'b1;
         iack_q     <= 1'b0;
         iack_lvl_q <= 3'd0;
      end else begin
         vpa_q      <= vpa_d;
         iack_q     <= iack_d;
         iack_lvl_q <= iack_lvl_d;
      end
   end

   assign bus._cpu_ipl    = ipl_q;
   assign bus._cpu_vpa    = vpa_q;
   assign bus.iack        = iack_q;
   assign bus.iack_level  = iack_lvl_q;
   assign bus.nmi_pending = nmi_q;
endmodule

// File: tb/tb_irq_ipl_ctrl.sv
// Self-checking bench for irq_ipl_ctrl: directed scenarios plus randomized traffic
// compared against a sample-window / protocol-level reference model.
module tb_irq_ipl_ctrl;
   localparam int STABLE_CNT = 2;
   localparam int VPA_DLY    = 3;

   logic clk = 1'b0;
   logic _reset;
   irq_ipl_if bus();

   irq_ipl_ctrl #(.STABLE_CNT(STABLE_CNT), .VPA_DLY(VPA_DLY)) dut (
      .clk(clk), ._reset(_reset), .bus(bus));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [2:0] hist[$];
   logic       stable_m;
   logic [2:0] stable_val_m;
   logic [2:0] ipl_m;
   logic       nmi_m, int7_prev_m;
   logic       vpa_m, iack_m, wait_m;
   logic [2:0] lvl_m, cap_m;
   int         left_m;

   function automatic logic [2:0] want_level(logic i7, logic nmi, logic [2:0] p);
      if (i7 || nmi) return 3'd7;
      return (p > 3'd6) ? 3'd6 : p;
   endfunction

   task automatic model_reset();
      hist.delete();
      stable_m = 1'b0; stable_val_m = 3'd0; ipl_m = 3'b111;
      nmi_m = 1'b0; int7_prev_m = 1'b0;
      vpa_m = 1'b1; iack_m = 1'b0; wait_m = 1'b0; lvl_m = 3'd0; cap_m = 3'd0; left_m = 0;
   endtask

   // One clock: model advances on the rising edge from the inputs held since the last falling edge.
   task automatic step();
      logic [2:0] r;
      logic       nmi_n, hit;
      @(posedge clk);
      r   = want_level(bus.int7, nmi_m, bus.paula_ipl);
      hit = !bus._cpu_as && bus.cpu_fc == 3'd7 && bus.cpu_rd &&
            (&bus.cpu_address[23:4]) && bus.cpu_address[3:1] != 3'd0;
      if (bus.int7 && !int7_prev_m) nmi_n = 1'b1;
      else if (iack_m && lvl_m == 3'd7) nmi_n = 1'b0;
      else nmi_n = nmi_m;
      int7_prev_m = bus.int7;
      nmi_m = nmi_n;
      if (stable_m) ipl_m = ~stable_val_m;
      if (bus.clk7_en) begin
         hist.push_back(r);
         if (hist.size() > STABLE_CNT) void'(hist.pop_front());
         stable_m = (hist.size() == STABLE_CNT);
         foreach (hist[k]) if (hist[k] != hist[0]) stable_m = 1'b0;
         stable_val_m = hist[0];
      end
      iack_m = 1'b0;
      if (!vpa_m) begin
         if (bus._cpu_as) vpa_m = 1'b1;
      end else if (wait_m) begin
         if (bus._cpu_as) wait_m = 1'b0;
         else if (bus.clk7_en) begin
            left_m--;
            if (left_m == 0) begin
               wait_m = 1'b0; vpa_m = 1'b0; iack_m = 1'b1; lvl_m = cap_m;
            end
         end
      end else if (hit) begin
         wait_m = 1'b1; left_m = VPA_DLY; cap_m = bus.cpu_address[3:1];
      end
      @(negedge clk);
   endtask

   task automatic bus_idle();
      bus._cpu_as = 1'b1; bus.cpu_fc = 3'd0; bus.cpu_rd = 1'b0; bus.cpu_address = 23'd0;
   endtask

   // Runs one complete IACK bus cycle and reports what was observed.
   task automatic drive_iack(input logic [2:0] lvl, input int hold, output int lat,
                             output int pulses, output logic [2:0] seen,
                             output logic held_ok, output logic rel_ok);
      int ticks = 0;
      lat = -1; pulses = 0; seen = 3'd0; held_ok = 1'b1; rel_ok = 1'b0;
      bus.cpu_address = {20'hFFFFF, lvl}; bus.cpu_fc = 3'd7; bus.cpu_rd = 1'b1; bus._cpu_as = 1'b0;
      bus.clk7_en = 1'($urandom_range(0, 1));
      step();
      for (int c = 0; c < 200 && lat < 0; c++) begin
         bus.clk7_en = 1'($urandom_range(0, 1));
         step();
         if (bus.clk7_en) ticks++;
         if (bus.iack) begin pulses++; seen = bus.iack_level; end
         if (!bus._cpu_vpa) lat = ticks;
      end
      for (int c = 0; c < hold; c++) begin
         bus.clk7_en = 1'($urandom_range(0, 1));
         step();
         if (bus._cpu_vpa) held_ok = 1'b0;
         if (bus.iack) pulses++;
      end
      bus_idle();
      step();
      rel_ok = bus._cpu_vpa;
      if (bus.iack) pulses++;
      for (int c = 0; c < 4; c++) begin
         step();
         if (bus.iack) pulses++;
      end
   endtask

   task automatic test_reset();
      _reset = 1'b0;
      bus.clk7_en = 1'b0; bus.paula_ipl = 3'd0; bus.int7 = 1'b0;
      bus_idle();
      model_reset();
      repeat (2) @(negedge clk);
      checks++; if (bus._cpu_ipl !== 3'b111) begin errors++; $display("FAIL reset_ipl got %b want 111", bus._cpu_ipl); end
      checks++; if (bus._cpu_vpa !== 1'b1) begin errors++; $display("FAIL reset_vpa got %b want 1", bus._cpu_vpa); end
      checks++; if (bus.iack !== 1'b0) begin errors++; $display("FAIL reset_iack got %b want 0", bus.iack); end
      checks++; if (bus.iack_level !== 3'd0) begin errors++; $display("FAIL reset_iack_level got %0d want 0", bus.iack_level); end
      checks++; if (bus.nmi_pending !== 1'b0) begin errors++; $display("FAIL reset_nmi got %b want 0", bus.nmi_pending); end
      _reset = 1'b1;
   endtask

   task automatic test_paula_level();
      int ticks = 0;
      logic saw_glitch = 1'b0;
      bus.paula_ipl = 3'd3;
      for (int c = 0; c < 200 && ticks < STABLE_CNT; c++) begin
         bus.clk7_en = 1'($urandom_range(0, 1));
         step();
         if (bus.clk7_en) ticks++;
         if (ticks < STABLE_CNT) begin
            checks++; if (bus._cpu_ipl !== 3'b111) begin errors++; $display("FAIL paula_early got %b want 111", bus._cpu_ipl); end
         end
      end
      checks++; if (ticks != STABLE_CNT) begin errors++; $display("FAIL paula_ticks got %0d want %0d", ticks, STABLE_CNT); end
      checks++; if (bus._cpu_ipl !== 3'b111) begin errors++; $display("FAIL paula_plus1 got %b want 111", bus._cpu_ipl); end
      bus.clk7_en = 1'b0;
      step();
      checks++; if (bus._cpu_ipl !== 3'b100) begin errors++; $display("FAIL paula_lvl3 got %b want 100", bus._cpu_ipl); end
      // single-sample glitch to level 5
      bus.paula_ipl = 3'd5; bus.clk7_en = 1'b1;
      step();
      bus.paula_ipl = 3'd0;
      for (int c = 0; c < 40; c++) begin
         bus.clk7_en = 1'($urandom_range(0, 3) != 0);
         step();
         if (bus._cpu_ipl === 3'b010) saw_glitch = 1'b1;
      end
      checks++; if (saw_glitch) begin errors++; $display("FAIL paula_glitch got 010 want never"); end
      checks++; if (bus._cpu_ipl !== 3'b111) begin errors++; $display("FAIL paula_lvl0 got %b want 111", bus._cpu_ipl); end
   endtask

   task automatic test_nmi();
      int lat, pulses, c;
      logic [2:0] seen;
      logic held_ok, rel_ok;
      bus.paula_ipl = 3'd4; bus.clk7_en = 1'b1;
      repeat (STABLE_CNT + 2) step();
      checks++; if (bus._cpu_ipl !== 3'b011) begin errors++; $display("FAIL nmi_paula4 got %b want 011", bus._cpu_ipl); end
      bus.int7 = 1'b1; bus.clk7_en = 1'b0;
      step();
      bus.int7 = 1'b0;
      checks++; if (bus.nmi_pending !== 1'b1) begin errors++; $display("FAIL nmi_latch got %b want 1", bus.nmi_pending); end
      bus.clk7_en = 1'b1;
      repeat (STABLE_CNT + 2) step();
      checks++; if (bus._cpu_ipl !== 3'b000) begin errors++; $display("FAIL nmi_ipl7 got %b want 000", bus._cpu_ipl); end
      drive_iack(3'd7, 2, lat, pulses, seen, held_ok, rel_ok);
      checks++; if (lat != VPA_DLY) begin errors++; $display("FAIL nmi_vpa_latency got %0d want %0d", lat, VPA_DLY); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL nmi_iack_pulses got %0d want 1", pulses); end
      checks++; if (seen !== 3'd7) begin errors++; $display("FAIL nmi_iack_level got %0d want 7", seen); end
      checks++; if (bus.nmi_pending !== 1'b0) begin errors++; $display("FAIL nmi_retire got %b want 0", bus.nmi_pending); end
      for (c = 0; c < 60 && bus._cpu_ipl !== 3'b011; c++) begin
         bus.clk7_en = 1'($urandom_range(0, 1));
         step();
      end
      checks++; if (bus._cpu_ipl !== 3'b011) begin errors++; $display("FAIL nmi_ipl_back got %b want 011", bus._cpu_ipl); end
   endtask

   task automatic test_normal_iack();
      int lat, pulses;
      logic [2:0] seen;
      logic held_ok, rel_ok;
      drive_iack(3'd2, $urandom_range(1, 5), lat, pulses, seen, held_ok, rel_ok);
      checks++; if (lat != VPA_DLY) begin errors++; $display("FAIL iack2_latency got %0d want %0d", lat, VPA_DLY); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL iack2_pulses got %0d want 1", pulses); end
      checks++; if (seen !== 3'd2) begin errors++; $display("FAIL iack2_level got %0d want 2", seen); end
      checks++; if (!held_ok) begin errors++; $display("FAIL iack2_vpa_hold got released want held"); end
      checks++; if (!rel_ok) begin errors++; $display("FAIL iack2_vpa_release got 0 want 1"); end
      checks++; if (bus.iack_level !== 3'd2) begin errors++; $display("FAIL iack2_level_hold got %0d want 2", bus.iack_level); end
   endtask

   task automatic test_abort();
      int bad = 0;
      int lat, pulses;
      logic [2:0] seen, lvl;
      logic held_ok, rel_ok;
      bus.cpu_address = {20'hFFFFF, 3'd5}; bus.cpu_fc = 3'd7; bus.cpu_rd = 1'b1; bus._cpu_as = 1'b0;
      bus.clk7_en = 1'b1;
      step();
      for (int c = 0; c < VPA_DLY - 1 + int'($urandom_range(0, 3)); c++) begin
         bus.clk7_en = (c < VPA_DLY - 1) ? 1'b1 : 1'b0;
         step();
         if (!bus._cpu_vpa || bus.iack) bad++;
      end
      bus_idle(); bus.clk7_en = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         if (!bus._cpu_vpa || bus.iack) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", bad); end
      lvl = 3'($urandom_range(1, 6));
      drive_iack(lvl, 1, lat, pulses, seen, held_ok, rel_ok);
      checks++; if (lat != VPA_DLY) begin errors++; $display("FAIL abort_next_latency got %0d want %0d", lat, VPA_DLY); end
      checks++; if (pulses != 1 || seen !== lvl) begin errors++; $display("FAIL abort_next_iack got %0d/%0d want 1/%0d", pulses, seen, lvl); end
   endtask

   task automatic test_collision();
      int c;
      bus.int7 = 1'b0;
      bus.cpu_address = {20'hFFFFF, 3'd7}; bus.cpu_fc = 3'd7; bus.cpu_rd = 1'b1; bus._cpu_as = 1'b0;
      step();
      for (c = 0; c < 200 && bus.iack !== 1'b1; c++) begin
         bus.clk7_en = 1'($urandom_range(0, 1));
         step();
      end
      checks++; if (bus.iack !== 1'b1 || bus.iack_level !== 3'd7) begin errors++; $display("FAIL coll_pulse got %b/%0d want 1/7", bus.iack, bus.iack_level); end
      bus.int7 = 1'b1;
      step();
      checks++; if (bus.nmi_pending !== 1'b1) begin errors++; $display("FAIL coll_set_wins got %b want 1", bus.nmi_pending); end
      bus_idle();
      repeat (3) step();
      bus.int7 = 1'b0;
      repeat (3) step();
      checks++; if (bus.nmi_pending !== 1'b1) begin errors++; $display("FAIL coll_hold got %b want 1", bus.nmi_pending); end
   endtask

   task automatic test_async_reset();
      int c;
      bus.cpu_address = {20'hFFFFF, 3'd3}; bus.cpu_fc = 3'd7; bus.cpu_rd = 1'b1; bus._cpu_as = 1'b0;
      bus.clk7_en = 1'b1;
      step();
      for (c = 0; c < 50 && bus._cpu_vpa !== 1'b0; c++) step();
      checks++; if (bus._cpu_vpa !== 1'b0) begin errors++; $display("FAIL areset_pre_vpa got %b want 0", bus._cpu_vpa); end
      #2 _reset = 1'b0;
      #1;
      checks++; if (bus._cpu_vpa !== 1'b1) begin errors++; $display("FAIL areset_vpa got %b want 1", bus._cpu_vpa); end
      checks++; if (bus._cpu_ipl !== 3'b111) begin errors++; $display("FAIL areset_ipl got %b want 111", bus._cpu_ipl); end
      checks++; if (bus.nmi_pending !== 1'b0) begin errors++; $display("FAIL areset_nmi got %b want 0", bus.nmi_pending); end
      checks++; if (bus.iack_level !== 3'd0) begin errors++; $display("FAIL areset_level got %0d want 0", bus.iack_level); end
      model_reset();
      bus_idle(); bus.paula_ipl = 3'd0; bus.int7 = 1'b0;
      @(negedge clk);
      _reset = 1'b1;
   endtask

   task automatic test_random();
      int as_cnt = 0;
      int kind;
      for (int c = 0; c < 3000; c++) begin
         if (as_cnt == 0) begin
            if (bus._cpu_as) begin
               kind = $urandom_range(0, 7);
               bus._cpu_as = 1'b0;
               if (kind < 5) bus.cpu_address = {20'hFFFFF, 3'($urandom_range(0, 7))};
               else bus.cpu_address = 23'($urandom);
               bus.cpu_fc = (kind < 6) ? 3'd7 : 3'($urandom_range(0, 7));
               bus.cpu_rd = ($urandom_range(0, 7) != 0);
               as_cnt = $urandom_range(1, 12);
            end else begin
               bus._cpu_as = 1'b1;
               as_cnt = $urandom_range(0, 2);
            end
         end else begin
            as_cnt--;
         end
         if ($urandom_range(0, 3) == 0) bus.paula_ipl = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) bus.int7 = ~bus.int7;
         bus.clk7_en = 1'($urandom_range(0, 1));
         step();
         checks++; if (bus._cpu_ipl !== ipl_m) begin errors++; $display("FAIL rnd_ipl cyc %0d got %b want %b", c, bus._cpu_ipl, ipl_m); end
         checks++; if (bus._cpu_vpa !== vpa_m) begin errors++; $display("FAIL rnd_vpa cyc %0d got %b want %b", c, bus._cpu_vpa, vpa_m); end
         checks++; if (bus.iack !== iack_m) begin errors++; $display("FAIL rnd_iack cyc %0d got %b want %b", c, bus.iack, iack_m); end
         checks++; if (bus.iack_level !== lvl_m) begin errors++; $display("FAIL rnd_level cyc %0d got %0d want %0d", c, bus.iack_level, lvl_m); end
         checks++; if (bus.nmi_pending !== nmi_m) begin errors++; $display("FAIL rnd_nmi cyc %0d got %b want %b", c, bus.nmi_pending, nmi_m); end
      end
   endtask

   initial begin
      test_reset();
      test_paula_level();
      test_nmi();
      test_normal_iack();
      test_abort();
      test_collision();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
